neuron_update_seq: RTL and testbench

Per-tick neuron update sequencer for the neuron datapath. On each tick it walks every neuron index and time-multiplexes one shared combinational ALU through integrate, leak, threshold-compare and write-back. It reads and writes neuron state through an external potential/synapse store and emits one spike event per firing neuron. It sits between the core tick generator, the neuron state memory and the ALU instance.

---
 rtl/neuron_update_seq.sv | 140 ++++++++++++++
 tb/tb_neuron_update_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_update_seq.sv
// Per-tick neuron sweep: for each index, load state, integrate synaptic input,
// apply leak, compare to threshold and write back, sharing one external ALU.
module neuron_update_seq #(
  parameter int N_NEURONS = 16,
  parameter int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [31:0]      leak,
  input  logic [31:0]      threshold,
  input  logic [31:0]      reset_v,
  output logic [IDX_W-1:0] mem_addr,
  input  logic [31:0]      v_rdata,
  input  logic [31:0]      syn_rdata,
  output logic             v_we,
  output logic [31:0]      v_wdata,
  output logic             syn_clr,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx,
  output logic [2:0]       alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_f,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADD,
    LEAK,
    CMP,
    WB,
    DONE
  } state_t;

  localparam logic [2:0]       OP_ADD   = 3'd0;
  localparam logic [2:0]       OP_SUB   = 3'd3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      v_q;
  logic [31:0]      syn_q;
  logic             fire_q;

  // Sequencer: v_q carries the potential through each ALU pass of a neuron.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx_q  <= '0;
      v_q    <= '0;
      syn_q  <= '0;
      fire_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            idx_q <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          v_q   <= v_rdata;
          syn_q <= syn_rdata;
          state <= ADD;
        end
        ADD: begin
          v_q   <= alu_f;
          state <= LEAK;
        end
        LEAK: begin
          v_q   <= alu_f;
          state <= CMP;
        end
        CMP: begin
          // Wrapped difference sign: zero or positive means the neuron fires.
          fire_q <= ~alu_f[31];
          state  <= WB;
        end
        WB: begin
          if (idx_q == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
            state <= LOAD;
          end
        end
        DONE: begin
          idx_q <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_addr = idx_q;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_comb begin
    v_we        = 1'b0;
    syn_clr     = 1'b0;
    spike_valid = 1'b0;
    spike_idx   = '0;
    v_wdata     = '0;
    alu_op      = OP_ADD;
    alu_a       = '0;
    alu_b       = '0;
    case (state)
      ADD: begin
        alu_op = OP_ADD;
        alu_a  = v_q;
        alu_b  = syn_q;
      end
      LEAK: begin
        alu_op = OP_SUB;
        alu_a  = v_q;
        alu_b  = leak;
      end
      CMP: begin
        alu_op = OP_SUB;
        alu_a  = v_q;
        alu_b  = threshold;
      end
      WB: begin
        v_we        = 1'b1;
        syn_clr     = 1'b1;
        v_wdata     = fire_q ? reset_v : v_q;
        spike_valid = fire_q;
        spike_idx   = idx_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_neuron_update_seq.sv
// Randomized and directed bench for neuron_update_seq with a behavioural
// state store, ALU and per-sweep reference model.
module tb_neuron_update_seq;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [31:0]   leak, threshold, reset_v;
  logic [IW-1:0] mem_addr, spike_idx;
  logic [31:0]   v_rdata, syn_rdata, v_wdata, alu_a, alu_b, alu_f;
  logic          v_we, syn_clr, spike_valid, busy, done;
  logic [2:0]    alu_op;

  logic [31:0] v_mem   [N];
  logic [31:0] syn_mem [N];
  int          wcount  [N];
  logic [31:0] exp_w   [N];
  logic        exp_f   [N];
  logic [31:0] orig_v  [N];
  logic [31:0] orig_s  [N];

  int errors = 0;
  int checks = 0;

  neuron_update_seq #(.N_NEURONS(N)) dut (
    .clk(clk), .rst(rst), .tick(tick), .leak(leak), .threshold(threshold),
    .reset_v(reset_v), .mem_addr(mem_addr), .v_rdata(v_rdata),
    .syn_rdata(syn_rdata), .v_we(v_we), .v_wdata(v_wdata), .syn_clr(syn_clr),
    .spike_valid(spike_valid), .spike_idx(spike_idx), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign v_rdata   = v_mem[mem_addr];
  assign syn_rdata = syn_mem[mem_addr];

  // Behavioural ALU with the documented opcode map.
  always_comb begin
    case (alu_op)
      3'd0: alu_f = alu_a + alu_b;
      3'd1: alu_f = alu_a << alu_b[4:0];
      3'd2: alu_f = $signed(alu_a) >>> alu_b[4:0];
      3'd3: alu_f = alu_a - alu_b;
      3'd4: alu_f = alu_a ^ alu_b;
      3'd5: alu_f = alu_a >> alu_b[4:0];
      3'd6: alu_f = alu_a | alu_b;
      default: alu_f = alu_a & alu_b;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Runs one sweep; abortAt > 0 raises rst after the checks of that cycle.
  task automatic applyStimulus(input bit holdTick, input int abortAt);
    logic [31:0] nv, diff;
    bit aborted = 0;
    for (int i = 0; i < N; i++) begin
      nv        = v_mem[i] + syn_mem[i] - leak;
      diff      = nv - threshold;
      exp_f[i]  = ~diff[31];
      exp_w[i]  = exp_f[i] ? reset_v : nv;
      orig_v[i] = v_mem[i];
      orig_s[i] = syn_mem[i];
      wcount[i] = 0;
    end
    tick = 1'b1;
    for (int c = 1; c <= 5 * N + 1; c++) begin
      int n, p;
      @(negedge clk);
      if (!holdTick || c == 5 * N + 1) tick = 1'b0;
      n = (c - 1) / 5;
      p = (c - 1) % 5;
      checkOutput("busy", busy, 1);
      if (c <= 5 * N) begin
        checkOutput("addr", mem_addr, n);
        checkOutput("v_we", v_we, p == 4);
        checkOutput("syn_clr", syn_clr, p == 4);
        checkOutput("done", done, 0);
        case (p)
          1: begin
            checkOutput("add_op", alu_op, 0);
            checkOutput("add_a", alu_a, orig_v[n]);
            checkOutput("add_b", alu_b, orig_s[n]);
          end
          2: begin
            checkOutput("leak_op", alu_op, 3);
            checkOutput("leak_b", alu_b, leak);
          end
          3: begin
            checkOutput("cmp_op", alu_op, 3);
            checkOutput("cmp_b", alu_b, threshold);
          end
          4: begin
            checkOutput("wdata", v_wdata, exp_w[n]);
            checkOutput("spike", spike_valid, exp_f[n]);
            if (exp_f[n]) checkOutput("spike_idx", spike_idx, n);
          end
          default: checkOutput("spike_idle", spike_valid, 0);
        endcase
      end else begin
        checkOutput("done", done, 1);
        checkOutput("v_we_done", v_we, 0);
      end
      if (v_we) begin
        v_mem[mem_addr] = v_wdata;
        wcount[mem_addr]++;
      end
      if (syn_clr) syn_mem[mem_addr] = '0;
      if (c == abortAt) begin
        rst = 1'b1;
        aborted = 1;
        break;
      end
    end
    @(negedge clk);
    checkOutput("busy_after", busy, 0);
    checkOutput("v_we_after", v_we, 0);
    checkOutput("syn_clr_after", syn_clr, 0);
    checkOutput("spike_after", spike_valid, 0);
    checkOutput("done_after", done, 0);
    if (aborted) begin
      rst = 1'b0;
      checkOutput("abort_w0", wcount[0], 1);
      checkOutput("abort_w1", wcount[1], 0);
      checkOutput("abort_v1", v_mem[1], orig_v[1]);
    end else begin
      for (int i = 0; i < N; i++) checkOutput("wcount", wcount[i], 1);
    end
  endtask

  task automatic fillMem(input logic [31:0] v, input logic [31:0] s);
    for (int i = 0; i < N; i++) begin
      v_mem[i]   = v;
      syn_mem[i] = s;
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1;
    leak = '0; threshold = '0; reset_v = '0;
    fillMem('0, '0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_v_we", v_we, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_addr", mem_addr, 0);
      checkOutput("rst_alu_a", alu_a, 0);
    end
    rst = 1'b0; tick = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);

    // No fire: 10 + 5 - 2 = 13 everywhere
    fillMem(32'd10, 32'd5); leak = 32'd2; threshold = 32'd100; reset_v = 32'd0;
    applyStimulus(0, 0);
    checkOutput("nofire_v0", v_mem[0], 32'd13);

    // Exact threshold on neuron 2
    fillMem(32'd10, 32'd5); v_mem[2] = 32'd90; syn_mem[2] = 32'd12;
    applyStimulus(0, 0);
    checkOutput("exact_v2", v_mem[2], 32'd0);
    checkOutput("exact_v3", v_mem[3], 32'd13);

    // Negative path
    fillMem(-32'sd50, 32'd0); leak = 32'd10; threshold = -32'sd55; reset_v = 32'd7;
    applyStimulus(0, 0);
    checkOutput("neg_v1", v_mem[1], 32'hFFFFFFC4);
    fillMem(-32'sd50, 32'd0); threshold = -32'sd60;
    applyStimulus(0, 0);
    checkOutput("neg_fire_v1", v_mem[1], 32'd7);

    // Wrap-around
    fillMem(32'h7FFFFFFF, 32'd1); leak = 32'd0; threshold = 32'd0; reset_v = 32'd0;
    applyStimulus(0, 0);
    checkOutput("wrap_v0", v_mem[0], 32'h80000000);

    // tick held high through the sweep
    fillMem(32'd20, 32'd3); leak = 32'd1; threshold = 32'd22; reset_v = 32'd5;
    applyStimulus(1, 0);

    // Reset during LEAK of neuron 1
    fillMem(32'd30, 32'd4); v_mem[1] = 32'd77;
    applyStimulus(0, 8);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        v_mem[i]   = (r == 5) ? $urandom : 32'($urandom_range(400) - 200);
        syn_mem[i] = (r == 5) ? $urandom : 32'($urandom_range(100));
      end
      leak      = (r == 5) ? $urandom : 32'($urandom_range(20));
      threshold = (r == 5) ? $urandom : 32'($urandom_range(400) - 200);
      reset_v   = $urandom;
      applyStimulus(r[0], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
